bus_master_ctrl: RTL
====================

# bus_master_ctrl

Bus-master interface controller that sequences one CPU-side memory access at a time onto the shared bus. It requests the bus from the arbiter, waits for grant, and issues a single-cycle address strobe with address, direction and write data. It then waits for slave ready, returns read data with a completion pulse, and releases the bus. One instance sits between each pipeline access port (IF, MEM) and a master port of `bus_top`.

## Interface
- `ADDR_WIDTH`, default 30: word address width, equal to the bus address width.
- `DATA_WIDTH`, default 32: data width.
- `TIMEOUT`, default 16: number of cycles in WAIT without `bus_rdy` before the access aborts with an error; legal range 1..255.
- `clk` input, 1 bit: the single clock; all logic on its rising edge.
- `rst_` input, 1 bit: **synchronous, active-high** reset.
- `req_valid` input, 1 bit: CPU access request.
- `req_ready` output, 1 bit: the controller can accept a request; equals 1 exactly when the state is IDLE.
- `req_rw` input, 1 bit: access direction, `READ`/`WRITE` encoding.
- `req_addr` input, ADDR_WIDTH: access address.
- `req_wr_data` input, DATA_WIDTH: write data.
- `done` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: timeout flag; valid while `done`=1.
- `rd_data` output, DATA_WIDTH: read result; valid while `done`=1 after a successful read, and held until the next successful read.
- `bus_req` output, 1 bit: bus request to the arbiter.
- `bus_grnt` input, 1 bit: grant from the arbiter.
- `bus_as` output, 1 bit: address strobe, active-high.
- `bus_addr` output, ADDR_WIDTH: bus address.
- `bus_wr` output, 1 bit: bus direction.
- `bus_wr_data` output, DATA_WIDTH: bus write data.
- `bus_rdy` input, 1 bit: ready from the selected slave.
- `bus_rd_data` input, DATA_WIDTH: read data from the selected slave.

## Operation
- States: IDLE, REQ, ACCESS, WAIT. The state register is the only control storage.
- IDLE: `bus_req`=0. If `req_valid`=1, latch `req_rw`, `req_addr` and `req_wr_data` into the bus registers, then go to REQ.
- REQ: `bus_req`=1. If `bus_grnt`=1, go to ACCESS; otherwise stay in REQ indefinitely (no grant timeout).
- ACCESS: `bus_req`=1 and `bus_as`=1 for exactly one cycle. Clear the wait counter, then go to WAIT.
- WAIT: `bus_req`=1 and `bus_as`=0. On each cycle:
  - If `bus_rdy`=1: go to IDLE and set `done`=1, `err`=0. For a read, capture `bus_rd_data` into `rd_data`; for a write, leave `rd_data` unchanged.
  - Else if the counter equals TIMEOUT-1: go to IDLE and set `done`=1, `err`=1. `rd_data` is unchanged.
  - Else increment the counter. The counter is an 8-bit unsigned value and never wraps.
- `bus_rdy` and the timeout condition in the same cycle: `bus_rdy` wins, and the access completes normally.
- `bus_addr`, `bus_wr` and `bus_wr_data` are driven from the latched registers and are stable from REQ through WAIT. Changes on `req_*` after acceptance are ignored.
- `bus_grnt` is ignored outside REQ. The arbiter keeps the grant while `bus_req` is held.
- `bus_rdy` is ignored outside WAIT.
- `req_valid` in any state other than IDLE is ignored. The CPU holds the request until `req_ready`=1.

## Timing
- All outputs are registered, or decoded from the state register alone (`req_ready`, `bus_req`, `bus_as`). No combinational path runs from inputs to outputs.
- Reset values:
  - state = IDLE, so `req_ready`=1.
  - `bus_req`=0, `bus_as`=0.
  - `bus_addr`=0, `bus_wr`=`READ`, `bus_wr_data`=0.
  - `done`=0, `err`=0, `rd_data`=0, counter = 0.
- Minimum latency, with request sampled at edge N:
  - REQ in N+1.
  - Grant sampled at the end of N+1; ACCESS with `bus_as`=1 in N+2.
  - WAIT in N+3; `bus_rdy` sampled at the end of N+3.
  - `done`=1 in N+4. Total: 4 cycles.
- Back-to-back: `req_ready`=1 in the same cycle as `done`, so the next request can be accepted then, giving one access per 4 cycles at best.
- Reset mid-operation: state returns to IDLE on the next edge. `bus_req` and `bus_as` drop within one cycle, and no `done` is issued for the aborted access.

## Test plan
- Read, grant and ready both immediately available: `req_addr`=0x000, memory word 0 = 0x12345678. Required: `bus_as` high in cycle N+2 only; `done`=1, `err`=0, `rd_data`=0x12345678 in N+4.
- Write followed by read-back: write 0xDEADBEEF to 0x004, then read 0x004. Required: `bus_wr`=`WRITE` during the first access; the second access returns `rd_data`=0xDEADBEEF; the two `done` pulses are 4 cycles apart.
- Grant delayed: arbiter grants another master for 3 cycles. Required: `bus_req`=1 throughout, `bus_as`=0 until the grant arrives, `done` at N+7.
- Timeout with TIMEOUT=4 and `bus_rdy` held 0. Required: exactly 4 WAIT cycles, then `done`=1, `err`=1, `rd_data` unchanged, `bus_req`=0 on the following cycle.
- Boundary: `bus_rdy` rises in the 4th WAIT cycle with TIMEOUT=4. Required: `err`=0 and data captured. Separately, reset asserted in WAIT: all outputs return to reset values next cycle and no `done` pulse occurs.

Source files
------------

// File: rtl/bus_master_ctrl.sv
// bus_master_ctrl
//   Sequences one CPU-side memory access at a time onto the shared bus:
//   request the bus, wait for grant, drive a one-cycle address strobe,
//   wait for slave ready (or time out), report completion, release the bus.
//
// Ports
//   clk, rst_          : clock, synchronous active-high reset
//   req_valid/ready    : CPU request handshake. A request transfers on a
//                        rising edge where req_valid=1 and req_ready=1; the
//                        CPU holds req_* stable until then and the
//                        controller ignores req_* at every other time.
//   req_rw/addr/wr_data: access direction (0=READ, 1=WRITE), address, data
//   done, err, rd_data : one-cycle completion pulse, timeout flag, read data
//   bus_req, bus_grnt  : arbiter request / grant
//   bus_as             : one-cycle address strobe
//   bus_addr/wr/wr_data: latched access, stable from REQ through WAIT
//   bus_rdy/rd_data    : slave ready and read data (sampled only in WAIT)
//   state_dbg          : current FSM state (0=IDLE 1=REQ 2=ACCESS 3=WAIT)
module bus_master_ctrl #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wr_data,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  bus_req,
    input  logic                  bus_grnt,
    output logic                  bus_as,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic                  bus_rdy,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic [1:0]            state_dbg
);

    localparam logic READ = 1'b0;

    // Last counter value before the access gives up; the counter starts at
    // 0 in the first WAIT cycle, so the access sees exactly TIMEOUT WAIT cycles.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    // Decoded from the state register only, so no input reaches an output
    // combinationally.
    assign req_ready = (state == IDLE);
    assign bus_req   = (state != IDLE);
    assign bus_as    = (state == ACCESS);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus_addr    <= '0;
            bus_wr      <= READ;
            bus_wr_data <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_data     <= '0;
        end else begin
            // done/err are pulses: only the WAIT exit raises them.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_wr      <= req_rw;
                        bus_addr    <= req_addr;
                        bus_wr_data <= req_wr_data;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grnt) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Ready is checked first so it beats a coincident timeout.
                    if (bus_rdy) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        if (bus_wr == READ) begin
                            rd_data <= bus_rd_data;
                        end
                    end else if (wait_cnt == LAST_CNT) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
